// File: rtl/amiga_clk_sequencer.sv
// Power-up sequencer for the Amiga core: qualifies PLL lock, holds the core in
// reset through a settle window, then generates the 28M/7M clock-enable phases.
module amiga_clk_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       core_reset_n,
    output logic       ce_28m,
    output logic       ce_7m,
    output logic       ce_7m_fall,
    output logic       ce_7m_q,
    output logic [1:0] seq_state,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic        r_s1;
    logic        r_s2;
    logic [15:0] r_settle_cnt;
    logic [3:0]  r_phase;
    logic [7:0]  r_lock_loss_count;
    logic        r_core_reset_n;
    logic        r_ce_28m;
    logic        r_ce_7m;
    logic        r_ce_7m_fall;
    logic        r_ce_7m_q;
    logic [3:0]  w_phase_next;

    assign w_phase_next = r_phase + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state           <= WAIT_LOCK;
            r_s1              <= 1'b0;
            r_s2              <= 1'b0;
            r_settle_cnt      <= '0;
            r_phase           <= '0;
            r_lock_loss_count <= '0;
            r_core_reset_n    <= 1'b0;
            r_ce_28m          <= 1'b0;
            r_ce_7m           <= 1'b0;
            r_ce_7m_fall      <= 1'b0;
            r_ce_7m_q         <= 1'b0;
        end else begin
            r_s1 <= pll_locked;
            r_s2 <= r_s1;
            // NOTE: enables default low each cycle so every pulse is exactly one clk
            // wide; the later assignments in the RUN branch override them.
            r_ce_28m     <= 1'b0;
            r_ce_7m      <= 1'b0;
            r_ce_7m_fall <= 1'b0;
            r_ce_7m_q    <= 1'b0;

            case (r_state)
                WAIT_LOCK: begin
                    if (r_s2) begin
                        r_state      <= SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!r_s2) begin
                        r_state      <= WAIT_LOCK;
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_state        <= RUN;
                        r_settle_cnt   <= '0;
                        r_phase        <= '0;
                        r_core_reset_n <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (!r_s2) begin
                        r_state        <= WAIT_LOCK;
                        r_phase        <= '0;
                        r_core_reset_n <= 1'b0;
                        if (r_lock_loss_count != 8'hFF)
                            r_lock_loss_count <= r_lock_loss_count + 8'd1;
                    end else begin
                        // Enables are registered, so decode the phase value being loaded.
                        r_phase      <= w_phase_next;
                        r_ce_28m     <= (w_phase_next[1:0] == 2'd3);
                        r_ce_7m      <= (w_phase_next == 4'd15);
                        r_ce_7m_fall <= (w_phase_next == 4'd7);
                        r_ce_7m_q    <= (w_phase_next == 4'd3);
                    end
                end
                default: begin
                    r_state        <= WAIT_LOCK;
                    r_settle_cnt   <= '0;
                    r_phase        <= '0;
                    r_core_reset_n <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset_n    = r_core_reset_n;
    assign ce_28m          = r_ce_28m;
    assign ce_7m           = r_ce_7m;
    assign ce_7m_fall      = r_ce_7m_fall;
    assign ce_7m_q         = r_ce_7m_q;
    assign seq_state       = r_state;
    assign lock_loss_count = r_lock_loss_count;

endmodule

// File: tb/tb_amiga_clk_sequencer.sv
// Directed bench for amiga_clk_sequencer with SETTLE_CYCLES=4: lock latency,
// enable phasing, lock loss, settle abort, glitch rejection, saturation, reset.
module tb_amiga_clk_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       core_reset_n;
    logic       ce_28m;
    logic       ce_7m;
    logic       ce_7m_fall;
    logic       ce_7m_q;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_count;

    int n_cmp = 0;
    int n_err = 0;

    amiga_clk_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .core_reset_n    (core_reset_n),
        .ce_28m          (ce_28m),
        .ce_7m           (ce_7m),
        .ce_7m_fall      (ce_7m_fall),
        .ce_7m_q         (ce_7m_q),
        .seq_state       (seq_state),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ce(input string tag, input logic e28, input logic e7,
                            input logic efall, input logic eq);
        check({tag, ".ce_28m"}, 16'(ce_28m), 16'(e28));
        check({tag, ".ce_7m"}, 16'(ce_7m), 16'(e7));
        check({tag, ".ce_7m_fall"}, 16'(ce_7m_fall), 16'(efall));
        check({tag, ".ce_7m_q"}, 16'(ce_7m_q), 16'(eq));
    endtask

    int c28, c7, cfall, cq, last_7m;

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        tick(2);
        check("rst.state", 16'(seq_state), 16'd0);
        check("rst.core", 16'(core_reset_n), 16'd0);
        check("rst.llc", 16'(lock_loss_count), 16'd0);
        check_ce("rst", 0, 0, 0, 0);

        // Drop lock while in SETTLE: back to WAIT_LOCK, no loss counted.
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        tick(2);
        check("abort.n1", 16'(seq_state), 16'd0);
        tick(1);
        check("abort.settle", 16'(seq_state), 16'd1);
        pll_locked = 1'b0;
        tick(2);
        check("abort.n4", 16'(seq_state), 16'd1);
        tick(1);
        check("abort.wait", 16'(seq_state), 16'd0);
        check("abort.core", 16'(core_reset_n), 16'd0);
        check("abort.llc", 16'(lock_loss_count), 16'd0);
        tick(3);

        // Sub-cycle glitch between edges must not be captured.
        pll_locked = 1'b1;
        #3 pll_locked = 1'b0;
        tick(4);
        check("glitch.state", 16'(seq_state), 16'd0);

        // Lock latency: first high sample at edge N.
        pll_locked = 1'b1;
        tick(2);
        check("lock.n1", 16'(seq_state), 16'd0);
        tick(1);
        check("lock.n2", 16'(seq_state), 16'd1);
        check("lock.n2.core", 16'(core_reset_n), 16'd0);
        tick(3);
        check("lock.n5", 16'(seq_state), 16'd1);
        check("lock.n5.core", 16'(core_reset_n), 16'd0);
        tick(1);
        check("lock.run", 16'(seq_state), 16'd2);
        check("lock.run.core", 16'(core_reset_n), 16'd1);
        check_ce("run.c1", 0, 0, 0, 0);
        tick(3);
        check_ce("run.c4", 1, 0, 0, 1);
        tick(4);
        check_ce("run.c8", 1, 0, 1, 0);
        tick(7);
        check_ce("run.c15", 0, 0, 0, 0);
        tick(1);
        check_ce("run.c16", 1, 1, 0, 0);

        // 64 cycles of steady RUN, starting just after a ce_7m pulse.
        c28 = 0; c7 = 0; cfall = 0; cq = 0; last_7m = 0;
        for (int i = 1; i <= 64; i++) begin
            tick(1);
            if (ce_28m) c28++;
            if (ce_7m_fall) begin
                cfall++;
                check("steady.fall_gap", 16'(i - last_7m), 16'd8);
            end
            if (ce_7m_q) begin
                cq++;
                check("steady.q_gap", 16'(i - last_7m), 16'd4);
            end
            if (ce_7m) begin
                c7++;
                last_7m = i;
            end
        end
        check("steady.n28", 16'(c28), 16'd16);
        check("steady.n7", 16'(c7), 16'd4);
        check("steady.nfall", 16'(cfall), 16'd4);
        check("steady.nq", 16'(cq), 16'd4);

        // Lock loss in RUN for 10 cycles, then relock with full settle.
        pll_locked = 1'b0;
        tick(2);
        check("loss.d1", 16'(seq_state), 16'd2);
        check("loss.d1.core", 16'(core_reset_n), 16'd1);
        tick(1);
        check("loss.d2", 16'(seq_state), 16'd0);
        check("loss.d2.core", 16'(core_reset_n), 16'd0);
        check("loss.d2.llc", 16'(lock_loss_count), 16'd1);
        check_ce("loss.d2", 0, 0, 0, 0);
        tick(7);
        pll_locked = 1'b1;
        tick(3);
        check("relock.settle", 16'(seq_state), 16'd1);
        tick(3);
        check("relock.n5", 16'(seq_state), 16'd1);
        tick(1);
        check("relock.run", 16'(seq_state), 16'd2);
        check_ce("relock.c1", 0, 0, 0, 0);
        tick(14);
        check_ce("relock.c15", 0, 0, 0, 0);
        tick(1);
        check_ce("relock.c16", 1, 1, 0, 0);

        // 300 further losses from RUN: count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            tick(7);
        end
        check("sat.run", 16'(seq_state), 16'd2);
        check("sat.llc", 16'(lock_loss_count), 16'd255);

        // Reset on the edge where a lock-loss increment would otherwise occur.
        pll_locked = 1'b0;
        tick(2);
        reset_n = 1'b0;
        tick(1);
        check("rrun.state", 16'(seq_state), 16'd0);
        check("rrun.core", 16'(core_reset_n), 16'd0);
        check("rrun.llc", 16'(lock_loss_count), 16'd0);
        check_ce("rrun", 0, 0, 0, 0);

        // Fresh power-up: lock must requalify through the synchronizer.
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        tick(2);
        check("fresh.n1", 16'(seq_state), 16'd0);
        tick(1);
        check("fresh.n2", 16'(seq_state), 16'd1);
        tick(4);
        check("fresh.run", 16'(seq_state), 16'd2);
        check("fresh.core", 16'(core_reset_n), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/amiga_clk_sequencer.md
AMIGA_CLK_SEQUENCER -- requirements
Module: amiga_clk_sequencer

Interface
REQ-001: Parameter SETTLE_CYCLES, default 1024, number of cycles pll_locked must stay high before the core leaves reset; legal range 1..65535.
REQ-002: clk  input  1  113.5 MHz master clock from the PLL; every register in this block is clocked on its rising edge.
REQ-003: reset_n  input  1  reset, synchronous and active-low.
REQ-004: pll_locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-005: core_reset_n  output  1  core reset, active-low, registered.
REQ-006: ce_28m  output  1  28.375 MHz clock enable, one clk wide, 1 in 4.
REQ-007: ce_7m  output  1  7.09 MHz rising-phase enable, one clk wide, 1 in 16.
REQ-008: ce_7m_fall  output  1  7.09 MHz falling-phase enable, 1 in 16.
REQ-009: ce_7m_q  output  1  7.09 MHz enable lagging ce_7m by a quarter period (4 clk), 1 in 16.
REQ-010: seq_state  output  2  FSM state: 0 = WAIT_LOCK, 1 = SETTLE, 2 = RUN.
REQ-011: lock_loss_count  output  8  saturating count of lock losses that occurred in RUN.

Function
REQ-012: pll_locked SHALL pass through a 2-flop synchronizer (s1, s2); the FSM SHALL use only s2.
REQ-013: WAIT_LOCK: when s2=1, go to SETTLE with settle_cnt=0; otherwise stay.
REQ-014: SETTLE: when s2=0, go to WAIT_LOCK and clear settle_cnt; lock_loss_count does not change.
REQ-015: SETTLE: when s2=1, increment settle_cnt; when settle_cnt==SETTLE_CYCLES-1, go to RUN. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
REQ-016: Lock latency: pll_locked first sampled high at edge N -> SETTLE after edge N+2 -> RUN and core_reset_n=1 after edge N+2+SETTLE_CYCLES.
REQ-017: core_reset_n SHALL be 1 only in RUN and SHALL be updated on the same edge as the state register.
REQ-018: phase is a 4-bit counter, held at 0 outside RUN; it is 0 in the first RUN cycle, increments every RUN cycle, and wraps 15->0.
REQ-019: Enable decode, all forced 0 outside RUN:
- ce_28m = (phase[1:0]==3)
- ce_7m = (phase==15)
- ce_7m_fall = (phase==7)
- ce_7m_q = (phase==3)
REQ-020: First pulse positions after entering RUN: ce_28m in RUN cycle 4, ce_7m_q in cycle 4, ce_7m_fall in cycle 8, ce_7m in cycle 16.
REQ-021: RUN with s2=0: next edge goes to WAIT_LOCK, core_reset_n=0, phase=0, all enables 0, lock_loss_count increments, saturating at 255.
REQ-022: pll_locked glitches shorter than one clk period that are not captured by s1 SHALL have no effect.
REQ-023: Relock after a loss SHALL repeat the full SETTLE period; no shortened path exists.

Reset
REQ-024: reset_n=0 at a clk edge SHALL set: state=WAIT_LOCK, s1=s2=0, settle_cnt=0, phase=0, lock_loss_count=0, core_reset_n=0, all ce_* outputs 0, seq_state=0.
REQ-025: Reset asserted in any state, including mid-RUN, SHALL take effect on that edge and override any lock-loss increment in the same cycle.
REQ-026: After reset_n returns to 1, the block SHALL behave as a fresh power-up; s2 must re-qualify lock.

Verification
REQ-027: SETTLE_CYCLES=4; pll_locked rises before edge 10 -> seq_state=1 after edge 12, core_reset_n=1 after edge 16.
REQ-028: In steady RUN over 64 cycles -> ce_28m=16 pulses, ce_7m=4, ce_7m_fall=4, ce_7m_q=4; ce_7m_q is exactly 4 clk after each ce_7m, and ce_7m_fall is 8 clk after each ce_7m.
REQ-029: In RUN, drop pll_locked for 10 cycles -> core_reset_n=0 two edges after the drop, lock_loss_count=1; re-lock -> full 4-cycle SETTLE, then first ce_7m in RUN cycle 16.
REQ-030: Drop pll_locked during SETTLE -> return to WAIT_LOCK, lock_loss_count stays 0, core_reset_n stays 0.
REQ-031: Force 300 lock losses from RUN -> lock_loss_count saturates at 255; reset_n=0 for 1 edge mid-RUN -> count=0, core_reset_n=0, state=WAIT_LOCK.
